// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: mid-bit sampling, LSB first, valid/ready holding register.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_os #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int NW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT
  } state_e;

  state_e               state_q, state_d;
  logic                 sync1_q, sync2_q;
  logic                 rx_s;
  logic [SW-1:0]        s_cnt_q, s_cnt_d;
  logic [NW-1:0]        n_cnt_q, n_cnt_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 stop_hit, commit;
`ifdef UART_RX_PARITY_EN
  logic                 perr_q, perr_d;
  logic                 rx_perr_q, rx_perr_d;
`endif

  assign rx_s = sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      s_cnt_q     <= '0;
      n_cnt_q     <= '0;
      sh_q        <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q      <= 1'b0;
      rx_perr_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sync1_q     <= rx;
      sync2_q     <= sync1_q;
      s_cnt_q     <= s_cnt_d;
      n_cnt_q     <= n_cnt_d;
      sh_q        <= sh_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      perr_q      <= perr_d;
      rx_perr_q   <= rx_perr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    sh_d    = sh_q;
`ifdef UART_RX_PARITY_EN
    perr_d  = perr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          s_cnt_d = '0;
        end
      end
      S_START: begin
        if (tick) begin
          if (s_cnt_q == S_HALF) begin
            if (rx_s) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_DATA;
              s_cnt_d = '0;
              n_cnt_d = '0;
            end
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (s_cnt_q == S_LAST) begin
            s_cnt_d = '0;
            sh_d    = {rx_s, sh_q[DATA_BITS-1:1]};
            n_cnt_d = n_cnt_q + 1'b1;
            if (n_cnt_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          if (s_cnt_q == S_LAST) begin
            s_cnt_d = '0;
            perr_d  = rx_s ^ (^sh_q);
            state_d = S_STOP;
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          if (s_cnt_q == S_LAST) begin
            s_cnt_d = '0;
            state_d = rx_s ? S_IDLE : S_WAIT;
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A pop in the commit cycle frees the slot, so the new word is loaded.
  always_comb begin
    stop_hit    = (state_q == S_STOP) && tick && (s_cnt_q == S_LAST);
    commit      = stop_hit && rx_s;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = stop_hit && !rx_s;
    overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    rx_perr_d   = rx_perr_q;
`endif
    if (commit) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = sh_q;
        rx_valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
        rx_perr_d  = perr_q;
`endif
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign rx_parity_err = rx_perr_q;
`else
  assign rx_parity_err = 1'b0;
`endif

endmodule
